// File: rtl/setbit_index_stream_int32_if.sv
// Word-in / set-bit-index-out handshake bundle for setbit_index_stream_int32.
// The master side is the producer and consumer pair. The slave side is the enumerator.
interface setbit_index_stream_int32_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [5:0]  out_ord;
    logic        out_last;
    logic        out_empty;

    modport master (
        output in_valid, A, out_ready,
        input  in_ready, out_valid, out_idx, out_ord, out_last, out_empty
    );

    modport slave (
        input  in_valid, A, out_ready,
        output in_ready, out_valid, out_idx, out_ord, out_last, out_empty
    );
endinterface

// File: rtl/setbit_index_stream_int32.sv
// Expands a 32-bit word into a stream of its set-bit positions, LSB first.
// Each beat also carries the 1-based ordinal of that bit. An all-zero word yields one empty beat.
module setbit_index_stream_int32 #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    setbit_index_stream_int32_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mask_q,  mask_d;
    logic [5:0]         ord_q,   ord_d;
    logic               empty_q, empty_d;

    logic               emit_s;
    logic               last_s;
    logic [4:0]         low_idx_s;

    // LSB-first priority encoder: the scan runs from high to low, so the lowest set bit wins.
    function automatic logic [4:0] lowest_set_idx(input logic [WIDTH-1:0] m);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = i[4:0];
            end
        end
        return idx;
    endfunction

    function automatic logic at_most_one_set(input logic [WIDTH-1:0] m);
        return ((m & (m - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
    endfunction

    // Output decode from registered state only; nothing here looks at in_valid or out_ready.
    always_comb begin
        emit_s        = (state_q == ST_EMIT);
        low_idx_s     = lowest_set_idx(mask_q);
        last_s        = empty_q || at_most_one_set(mask_q);
        bus.in_ready  = !emit_s;
        bus.out_valid = emit_s;
        if (emit_s) begin
            bus.out_idx   = low_idx_s;
            bus.out_ord   = empty_q ? 6'd0 : ord_q;
            bus.out_last  = last_s;
            bus.out_empty = empty_q;
        end else begin
            bus.out_idx   = 5'd0;
            bus.out_ord   = 6'd0;
            bus.out_last  = 1'b0;
            bus.out_empty = 1'b0;
        end
    end

    // Next-state logic: capture a word in IDLE, peel off one set bit per accepted beat in EMIT.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ord_d   = ord_q;
        empty_d = empty_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    mask_d  = bus.A;
                    ord_d   = 6'd1;
                    empty_d = (bus.A == {WIDTH{1'b0}});
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    mask_d = mask_q & (mask_q - {{(WIDTH-1){1'b0}}, 1'b1});
                    ord_d  = ord_q + 6'd1;
                    if (last_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. An asynchronous reset drops any partially emitted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= {WIDTH{1'b0}};
            ord_q   <= 6'd0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ord_q   <= ord_d;
            empty_q <= empty_d;
        end
    end

endmodule

// File: tb/tb_setbit_index_stream_int32.sv
// Randomized and directed bench for setbit_index_stream_int32.
// The bench holds a queue-based reference of the expected beats and compares every cycle.
module tb_setbit_index_stream_int32;

    typedef struct packed {
        logic [4:0] idx;
        logic [5:0] ord;
        logic       last;
        logic       empty;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;
    int   pat_cnt = 0;
    logic pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    beat_t exp_q [$];
    beat_t tmp_q [$];
    beat_t log_q [$];

    setbit_index_stream_int32_if bus ();

    setbit_index_stream_int32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Consumer-side ready: always on, random, or the fixed stall pattern once beats flow.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (bus.out_valid) begin
                    bus.out_ready = pat[pat_cnt];
                    if (pat_cnt < 7) pat_cnt = pat_cnt + 1;
                end else begin
                    bus.out_ready = pat[0];
                end
            end
            default: bus.out_ready = 1'b1;
        endcase
        if (rdy_mode != 2) pat_cnt = 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the beats of a word are its set bits in ascending order, numbered 1..popcount.
    function automatic void expand(input logic [31:0] a);
        int n;
        int c;
        beat_t b;
        tmp_q.delete();
        if (a == 32'd0) begin
            b = '{idx: 5'd0, ord: 6'd0, last: 1'b1, empty: 1'b1};
            tmp_q.push_back(b);
        end else begin
            n = $countones(a);
            c = 0;
            for (int i = 0; i < 32; i++) begin
                if (a[i]) begin
                    c = c + 1;
                    b.idx   = i[4:0];
                    b.ord   = c[5:0];
                    b.last  = (c == n);
                    b.empty = 1'b0;
                    tmp_q.push_back(b);
                end
            end
        end
    endfunction

    function automatic beat_t log_at(input int i);
        beat_t b;
        b = '1;
        if (i < log_q.size()) b = log_q[i];
        return b;
    endfunction

    function automatic beat_t mk(input int idx, input int ord, input logic last, input logic empty);
        beat_t b;
        b.idx   = idx[4:0];
        b.ord   = ord[5:0];
        b.last  = last;
        b.empty = empty;
        return b;
    endfunction

    task automatic mon_step();
        beat_t act;
        if (!rst_n) begin
            exp_q.delete();
            return;
        end
        act = {bus.out_idx, bus.out_ord, bus.out_last, bus.out_empty};
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_q.size() == 0});
        if (bus.out_valid && exp_q.size() != 0) chk("beat", {19'd0, act}, {19'd0, exp_q[0]});
        if (bus.out_valid && bus.out_ready) begin
            log_q.push_back(act);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (bus.in_valid && bus.in_ready) begin
            expand(bus.A);
            foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
        end
    endtask

    task automatic send_word(input logic [31:0] a);
        int n;
        bus.in_valid = 1'b1;
        bus.A        = a;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready && rst_n) begin
                @(posedge clk);
                #1;
                break;
            end
            n = n + 1;
            if (n > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic drop_valid();
        bus.in_valid = 1'b0;
        bus.A        = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.out_valid) break;
            n = n + 1;
            if (n > 300) begin
                chk("drain_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [31:0] w;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = 32'd0;
        bus.out_ready = 1'b1;

        expand(32'h0000_0A50);
        chk("model_a50_n", tmp_q.size(), 32'd4);
        chk("model_a50_b0", {19'd0, tmp_q[0]}, {19'd0, mk(4, 1, 1'b0, 1'b0)});
        chk("model_a50_b3", {19'd0, tmp_q[3]}, {19'd0, mk(11, 4, 1'b1, 1'b0)});
        expand(32'hFFFF_FFFF);
        chk("model_ff_n", tmp_q.size(), 32'd32);
        chk("model_ff_b31", {19'd0, tmp_q[31]}, {19'd0, mk(31, 32, 1'b1, 1'b0)});
        expand(32'h0);
        chk("model_zero", {19'd0, tmp_q[0]}, {19'd0, mk(0, 0, 1'b1, 1'b1)});

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_outs", {19'd0, bus.out_idx, bus.out_ord, bus.out_last, bus.out_empty}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        rdy_mode = 0;
        log_q.delete();
        send_word(32'h0);
        drop_valid();
        drain();
        chk("zero_n", log_q.size(), 32'd1);
        chk("zero_beat", {19'd0, log_at(0)}, {19'd0, mk(0, 0, 1'b1, 1'b1)});

        log_q.delete();
        send_word(32'h8000_0001);
        drop_valid();
        drain();
        chk("ends_n", log_q.size(), 32'd2);
        chk("ends_b0", {19'd0, log_at(0)}, {19'd0, mk(0, 1, 1'b0, 1'b0)});
        chk("ends_b1", {19'd0, log_at(1)}, {19'd0, mk(31, 2, 1'b1, 1'b0)});

        log_q.delete();
        send_word(32'hFFFF_FFFF);
        drop_valid();
        drain();
        chk("full_n", log_q.size(), 32'd32);
        chk("full_last", {19'd0, log_at(31)}, {19'd0, mk(31, 32, 1'b1, 1'b0)});
        chk("full_b30", {19'd0, log_at(30)}, {19'd0, mk(30, 31, 1'b0, 1'b0)});

        rdy_mode = 2;
        log_q.delete();
        send_word(32'h0000_0A50);
        drop_valid();
        drain();
        rdy_mode = 0;
        chk("a50_n", log_q.size(), 32'd4);
        chk("a50_b1", {19'd0, log_at(1)}, {19'd0, mk(6, 2, 1'b0, 1'b0)});
        chk("a50_b3", {19'd0, log_at(3)}, {19'd0, mk(11, 4, 1'b1, 1'b0)});

        log_q.delete();
        send_word(32'h3);
        send_word(32'h4);
        drop_valid();
        drain();
        chk("b2b_n", log_q.size(), 32'd3);
        chk("b2b_b1", {19'd0, log_at(1)}, {19'd0, mk(1, 2, 1'b1, 1'b0)});
        chk("b2b_b2", {19'd0, log_at(2)}, {19'd0, mk(2, 1, 1'b1, 1'b0)});

        log_q.delete();
        send_word(32'hF0F0_F0F0);
        drop_valid();
        n = 0;
        while (log_q.size() < 3 && n < 200) begin
            @(negedge clk);
            #1;
            n = n + 1;
        end
        chk("mid_beats_seen", log_q.size(), 32'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_rst_ord", {26'd0, bus.out_ord}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        log_q.delete();
        send_word(32'h2);
        drop_valid();
        drain();
        chk("post_rst_n", log_q.size(), 32'd1);
        chk("post_rst_beat", {19'd0, log_at(0)}, {19'd0, mk(1, 1, 1'b1, 1'b0)});

        rdy_mode = 1;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 4))
                0: w = 32'h0;
                1: w = 32'hFFFF_FFFF;
                2: w = $urandom & $urandom & $urandom;
                3: w = $urandom;
                default: w = 32'h1 << $urandom_range(0, 31);
            endcase
            send_word(w);
            if ($urandom_range(0, 1) == 0) begin
                drop_valid();
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        drop_valid();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
